// File: rtl/counter_updown_mod.sv
// Up/down counter with a programmable modulus, parallel load, wrap or saturate
// at the range ends, a terminal-count flag and a sticky overflow flag.
module counter_updown_mod #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   count_inc;
  logic             at_max, at_zero, wrap_ev;

  // Extra bit keeps count+1 == MODULUS comparable when MODULUS == 2**WIDTH.
  assign count_inc = {1'b0, count_q} + (WIDTH+1)'(1);
  assign at_max    = (count_inc == MOD_EXT);
  assign at_zero   = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_ev = 1'b0;
    if (load) begin
      count_d = (load_val <= MAX_VAL) ? load_val : MAX_VAL;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          wrap_ev = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = count_inc[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          wrap_ev = 1'b1;
          count_d = (SATURATE != 0) ? count_q : MAX_VAL;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    wrap_d = wrap_ev;
    // A wrap in the same cycle as clear_ovf leaves the flag set.
    ovf_d  = wrap_ev | (ovf_q & ~clear_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign tc    = up ? at_max : at_zero;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three instances (mod-10 wrap, mod-10 saturate,
// mod-16 wrap) share one stimulus; expected outputs go through a queue.
module tb_counter_updown_mod;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, up, load, clear_ovf;
  logic [3:0] load_val;
  logic [3:0] cw, cs, cf;
  logic       tw, ts, tf, ww, ws, wf, ow, os, of;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_w10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear_ovf(clear_ovf), .count(cw), .tc(tw), .wrap(ww), .ovf(ow));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear_ovf(clear_ovf), .count(cs), .tc(ts), .wrap(ws), .ovf(os));
  counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_w16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear_ovf(clear_ovf), .count(cf), .tc(tf), .wrap(wf), .ovf(of));

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       wrap;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e_i, input logic u, input logic l,
                       input logic [3:0] lv, input logic co);
    reset = r; en = e_i; up = u; load = l; load_val = lv; clear_ovf = co;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 4'd0, 0);
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL reset_w10: got %b want %b", {cw, tw, ww, ow}, e);
    end
    e = sb.pop_front(); n_chk++;
    if ({cs, ts, ws, os} !== e) begin
      n_fail++; $display("FAIL reset_s10: got %b want %b", {cs, ts, ws, os}, e);
    end
    e = sb.pop_front(); n_chk++;
    if ({cf, tf, wf, of} !== e) begin
      n_fail++; $display("FAIL reset_w16: got %b want %b", {cf, tf, wf, of}, e);
    end
  endtask

  task automatic test_count_up();
    for (int k = 1; k <= 12; k++) begin
      drive(0, 1, 1, 0, 4'd0, 0);
      sb.push_back('{4'(k % 10), (k % 10) == 9, k == 10, k >= 10});
      cyc();
      e = sb.pop_front(); n_chk++;
      if ({cw, tw, ww, ow} !== e) begin
        n_fail++; $display("FAIL count_up k=%0d: got %b want %b", k, {cw, tw, ww, ow}, e);
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] seq [4] = '{4'd2, 4'd1, 4'd0, 4'd9};
    drive(0, 0, 0, 1, 4'd3, 1);
    sb.push_back('{4'd3, 1'b0, 1'b0, 1'b0});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL down_load: got %b want %b", {cw, tw, ww, ow}, e);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 4'd0, 0);
      sb.push_back('{seq[k], seq[k] == 4'd0, k == 3, k == 3});
      cyc();
      e = sb.pop_front(); n_chk++;
      if ({cw, tw, ww, ow} !== e) begin
        n_fail++; $display("FAIL count_down k=%0d: got %b want %b", k, {cw, tw, ww, ow}, e);
      end
    end
  endtask

  task automatic test_saturate();
    drive(0, 0, 1, 1, 4'd8, 1);
    sb.push_back('{4'd8, 1'b0, 1'b0, 1'b0});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cs, ts, ws, os} !== e) begin
      n_fail++; $display("FAIL sat_load: got %b want %b", {cs, ts, ws, os}, e);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 4'd0, 0);
      sb.push_back('{4'd9, 1'b1, k > 0, k > 0});
      cyc();
      e = sb.pop_front(); n_chk++;
      if ({cs, ts, ws, os} !== e) begin
        n_fail++; $display("FAIL sat_up k=%0d: got %b want %b", k, {cs, ts, ws, os}, e);
      end
    end
    // Saturate low end: down from 0 holds at 0 and pulses wrap.
    drive(0, 0, 0, 1, 4'd0, 1);
    sb.push_back('{4'd0, 1'b1, 1'b0, 1'b0});
    cyc();
    drive(0, 1, 0, 0, 4'd0, 0);
    sb.push_back('{4'd0, 1'b1, 1'b1, 1'b1});
    cyc();
    e = sb.pop_front();
    e = sb.pop_front(); n_chk++;
    if ({cs, ts, ws, os} !== e) begin
      n_fail++; $display("FAIL sat_down: got %b want %b", {cs, ts, ws, os}, e);
    end
  endtask

  task automatic test_priority();
    drive(0, 1, 1, 1, 4'd13, 0);
    sb.push_back('{4'd9, 1'b1, 1'b0, 1'b1});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL load_clamp: got %b want %b", {cw, tw, ww, ow}, e);
    end
    drive(0, 1, 1, 0, 4'd0, 1);
    sb.push_back('{4'd0, 1'b0, 1'b1, 1'b1});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL clr_vs_wrap: got %b want %b", {cw, tw, ww, ow}, e);
    end
    drive(0, 0, 1, 0, 4'd0, 1);
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL clear_ovf: got %b want %b", {cw, tw, ww, ow}, e);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 1, 4'd9, 0);
    cyc();
    drive(0, 1, 1, 0, 4'd0, 0);
    cyc();
    drive(0, 0, 1, 1, 4'd5, 0);
    sb.push_back('{4'd5, 1'b0, 1'b0, 1'b1});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL pre_reset: got %b want %b", {cw, tw, ww, ow}, e);
    end
    drive(1, 1, 1, 1, 4'd7, 0);
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cw, tw, ww, ow} !== e) begin
      n_fail++; $display("FAIL reset_mid: got %b want %b", {cw, tw, ww, ow}, e);
    end
  endtask

  task automatic test_direction();
    // 0 -> up 1, 2 -> down 1, 0 -> down wraps to 9.
    logic       dir [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd9};
    drive(0, 0, 1, 0, 4'd0, 1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, dir[k], 0, 4'd0, 0);
      sb.push_back('{seq[k], dir[k] ? (seq[k] == 4'd9) : (seq[k] == 4'd0), k == 4, k == 4});
      cyc();
      e = sb.pop_front(); n_chk++;
      if ({cw, tw, ww, ow} !== e) begin
        n_fail++; $display("FAIL direction k=%0d: got %b want %b", k, {cw, tw, ww, ow}, e);
      end
    end
  endtask

  task automatic test_full_modulus();
    drive(0, 0, 1, 1, 4'd15, 1);
    sb.push_back('{4'd15, 1'b1, 1'b0, 1'b0});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cf, tf, wf, of} !== e) begin
      n_fail++; $display("FAIL m16_load: got %b want %b", {cf, tf, wf, of}, e);
    end
    drive(0, 1, 1, 0, 4'd0, 0);
    sb.push_back('{4'd0, 1'b0, 1'b1, 1'b1});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cf, tf, wf, of} !== e) begin
      n_fail++; $display("FAIL m16_wrap: got %b want %b", {cf, tf, wf, of}, e);
    end
    sb.push_back('{4'd1, 1'b0, 1'b0, 1'b1});
    cyc();
    e = sb.pop_front(); n_chk++;
    if ({cf, tf, wf, of} !== e) begin
      n_fail++; $display("FAIL m16_after: got %b want %b", {cf, tf, wf, of}, e);
    end
  endtask

  initial begin
    drive(1, 0, 1, 0, 4'd0, 0);
    cyc();
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_priority();
    test_reset_mid();
    test_direction();
    test_full_modulus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
